// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN job sequencer: address widths, FSM states and
// helpers that derive the output count and counter widths from the job geometry.
package cnn_pkg;

  localparam int ADR_W  = 8;
  localparam int ZADR_W = 7;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    FLUSH,
    DONE
  } state_t;

  // Number of outputs produced by a valid (no padding) 1-D convolution
  function automatic int calc_n_out(input int in_len, input int filt_size, input int stride);
    return (in_len - filt_size) / stride + 1;
  endfunction

  // Bits needed to count 0..n-1, never less than one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_job_sequencer_wr_delay_line.sv
// Fixed-depth shift line carrying {valid, output index} from the last-tap issue
// to the output write. It advances every cycle; the PE pipeline never stalls
// once a tap has been accepted.
module wr_delay_line #(
  parameter int DEPTH = 2,
  parameter int IDX_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_pending
);

  // Every stage except the output one; anything set here still has to come out
  localparam logic [DEPTH-1:0] TAIL_MASK = ~(DEPTH'(1) << (DEPTH - 1));

  logic [DEPTH-1:0] r_valid;
  logic [IDX_W-1:0] r_idx [DEPTH];

  // Shift valid and index one stage per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_idx[i] <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_idx[0]   <= i_idx;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_idx[i]   <= r_idx[i-1];
      end
    end
  end

  assign o_valid   = r_valid[DEPTH-1];
  assign o_idx     = r_idx[DEPTH-1];
  // After this cycle's shift the line is empty unless an earlier stage holds data
  assign o_pending = |(r_valid & TAIL_MASK);

endmodule

// File: rtl/conv_job_sequencer.sv
// Responder for one 1-D convolution job: latches the base addresses on start,
// walks every (output, tap) pair issuing scratchpad reads and MAC control,
// produces output writes after the PE latency and pulses done at the end.
module conv_job_sequencer
  import cnn_pkg::*;
#(
  parameter int FILT_SIZE = 4,
  parameter int IN_LEN    = 76,
  parameter int STRIDE    = 1,
  parameter int PIPE_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADR_W-1:0]  x_adr,
  input  logic [ADR_W-1:0]  y_adr,
  input  logic [ZADR_W-1:0] z_adr,
  input  logic              pe_ready,
  output logic              rd_en,
  output logic [ADR_W-1:0]  x_rd_adr,
  output logic [ADR_W-1:0]  y_rd_adr,
  output logic              mac_clr,
  output logic              mac_last,
  output logic              z_wr_en,
  output logic [ZADR_W-1:0] z_wr_adr,
  output logic              busy,
  output logic              done
);

  localparam int N_OUT = calc_n_out(IN_LEN, FILT_SIZE, STRIDE);
  localparam int K_W   = cnt_w(N_OUT);
  localparam int T_W   = cnt_w(FILT_SIZE);

  state_t            r_state;
  logic [ADR_W-1:0]  r_x_base;
  logic [ADR_W-1:0]  r_y_base;
  logic [ZADR_W-1:0] r_z_base;
  logic [K_W-1:0]    r_k;
  logic [T_W-1:0]    r_t;
  logic              r_busy;
  logic              r_done;

  logic              w_run;
  logic              w_issue;
  logic              w_tap_last;
  logic              w_out_last;
  logic [ADR_W-1:0]  w_x_off;
  logic              w_wr_valid;
  logic [K_W-1:0]    w_wr_k;
  logic              w_pending;

  assign w_run      = (r_state == RUN);
  assign w_issue    = w_run & pe_ready;
  assign w_tap_last = (r_t == T_W'(FILT_SIZE - 1));
  assign w_out_last = (r_k == K_W'(N_OUT - 1));
  // Input offset of the current tap; the sum wraps to the address width
  assign w_x_off    = ADR_W'(32'(r_k) * STRIDE) + ADR_W'(r_t);

  // Addresses are forced to zero outside RUN so an idle block shows a quiet bus
  assign rd_en    = w_issue;
  assign x_rd_adr = w_run ? (r_x_base + w_x_off) : '0;
  assign y_rd_adr = w_run ? (r_y_base + ADR_W'(r_t)) : '0;
  assign mac_clr  = w_issue & (r_t == '0);
  assign mac_last = w_issue & w_tap_last;
  assign z_wr_en  = w_wr_valid;
  assign z_wr_adr = w_wr_valid ? (r_z_base + ZADR_W'(w_wr_k)) : '0;
  assign busy     = r_busy;
  assign done     = r_done;

  wr_delay_line #(
    .DEPTH (PIPE_LAT),
    .IDX_W (K_W)
  ) u_wr_line (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (w_issue & w_tap_last),
    .i_idx     (r_k),
    .o_valid   (w_wr_valid),
    .o_idx     (w_wr_k),
    .o_pending (w_pending)
  );

  // Job FSM with tap/output counters, latched bases and registered busy/done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_x_base <= '0;
      r_y_base <= '0;
      r_z_base <= '0;
      r_k      <= '0;
      r_t      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_x_base <= x_adr;
            r_y_base <= y_adr;
            r_z_base <= z_adr;
            r_k      <= '0;
            r_t      <= '0;
            r_busy   <= 1'b1;
            r_state  <= LOAD;
          end
        end
        LOAD: begin
          r_k     <= '0;
          r_t     <= '0;
          r_state <= RUN;
        end
        RUN: begin
          // Counters only move on an accepted tap so stalls hold the addresses
          if (pe_ready) begin
            if (w_tap_last) begin
              r_t <= '0;
              if (w_out_last) begin
                r_k     <= '0;
                r_state <= FLUSH;
              end else begin
                r_k <= r_k + K_W'(1);
              end
            end else begin
              r_t <= r_t + T_W'(1);
            end
          end
        end
        FLUSH: begin
          // Leave once the final write is on the bus this cycle
          if (!w_pending) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_job_sequencer.sv
// Bench for conv_job_sequencer: a job-level model (issue index -> k,t; queue
// of pending writes keyed by due cycle) checked every cycle, plus literal pins.
module tb_conv_job_sequencer;

  localparam int F    = 4;
  localparam int LEN  = 76;
  localparam int S    = 1;
  localparam int PL   = 2;
  localparam int NOUT = (LEN - F) / S + 1;
  localparam int NISS = NOUT * F;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] x_adr, y_adr;
  logic [6:0] z_adr;
  logic       pe_ready;
  logic       rd_en, mac_clr, mac_last, z_wr_en, busy, done;
  logic [7:0] x_rd_adr, y_rd_adr;
  logic [6:0] z_wr_adr;

  // Second instance with stride 2 on a short map
  logic       start2;
  logic [7:0] x2_adr, y2_adr;
  logic [6:0] z2_adr;
  logic       rd_en2, mac_clr2, mac_last2, z_wr_en2, busy2, done2;
  logic [7:0] x_rd_adr2, y_rd_adr2;
  logic [6:0] z_wr_adr2;

  conv_job_sequencer #(.FILT_SIZE(F), .IN_LEN(LEN), .STRIDE(S), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .start(start), .x_adr(x_adr), .y_adr(y_adr), .z_adr(z_adr),
    .pe_ready(pe_ready), .rd_en(rd_en), .x_rd_adr(x_rd_adr), .y_rd_adr(y_rd_adr),
    .mac_clr(mac_clr), .mac_last(mac_last), .z_wr_en(z_wr_en), .z_wr_adr(z_wr_adr),
    .busy(busy), .done(done)
  );

  conv_job_sequencer #(.FILT_SIZE(4), .IN_LEN(12), .STRIDE(2), .PIPE_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .x_adr(x2_adr), .y_adr(y2_adr), .z_adr(z2_adr),
    .pe_ready(1'b1), .rd_en(rd_en2), .x_rd_adr(x_rd_adr2), .y_rd_adr(y_rd_adr2),
    .mac_clr(mac_clr2), .mac_last(mac_last2), .z_wr_en(z_wr_en2), .z_wr_adr(z_wr_adr2),
    .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Job model state
  bit m_job = 0;
  int m_iss_from, m_busy_from, m_issued, m_done_cyc;
  int m_xb, m_yb, m_zb;
  int wq_cyc[$];
  int wq_adr[$];

  // Per-test observations of the DUT
  int n_rd, n_wr, n_done, n_wrap_x, first_wr_adr, last_wr_adr, done_cyc_seen, t_start;
  int iss_x[4], iss_y[4], iss_clr[4], iss_last[4];

  // Stride-2 instance observations
  int d2_x[$];
  int d2_y[$];
  int d2_wr[$];
  int d2_done = 0;

  task automatic clear_stats();
    n_rd = 0; n_wr = 0; n_done = 0; n_wrap_x = 0;
    first_wr_adr = -1; last_wr_adr = -1; done_cyc_seen = -1;
  endtask

  // Per-cycle compare against the job model
  always @(negedge clk) begin : compare
    bit win, e_rd, e_wr, e_done, e_busy;
    int kk, tt;
    if (rst) begin
      m_job = 0;
      wq_cyc.delete();
      wq_adr.delete();
      chk("rst_rd_en", rd_en, 0);
      chk("rst_z_wr_en", z_wr_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_x_rd_adr", x_rd_adr, 0);
      chk("rst_z_wr_adr", z_wr_adr, 0);
    end else begin
      win    = m_job && (cyc >= m_iss_from) && (m_issued < NISS);
      kk     = m_issued / F;
      tt     = m_issued % F;
      e_rd   = win && pe_ready;
      e_wr   = (wq_cyc.size() > 0) && (wq_cyc[0] == cyc);
      e_done = m_job && (cyc == m_done_cyc);
      e_busy = m_job && (cyc >= m_busy_from);
      chk("rd_en", rd_en, e_rd);
      chk("z_wr_en", z_wr_en, e_wr);
      chk("done", done, e_done);
      chk("busy", busy, e_busy);
      if (win) begin
        chk("x_rd_adr", x_rd_adr, (m_xb + kk * S + tt) % 256);
        chk("y_rd_adr", y_rd_adr, (m_yb + tt) % 256);
        chk("mac_clr", mac_clr, e_rd && (tt == 0));
        chk("mac_last", mac_last, e_rd && (tt == F - 1));
      end
      if (e_wr) chk("z_wr_adr", z_wr_adr, wq_adr[0]);

      if (rd_en) begin
        if (n_rd < 4) begin
          iss_x[n_rd] = x_rd_adr; iss_y[n_rd] = y_rd_adr;
          iss_clr[n_rd] = mac_clr; iss_last[n_rd] = mac_last;
        end
        if (n_rd > 0 && x_rd_adr == 8'd0) n_wrap_x++;
        n_rd++;
      end
      if (z_wr_en) begin
        if (n_wr == 0) first_wr_adr = z_wr_adr;
        last_wr_adr = z_wr_adr;
        n_wr++;
      end
      if (done) begin
        n_done++;
        done_cyc_seen = cyc;
      end

      if (e_rd) begin
        if (tt == F - 1) begin
          wq_cyc.push_back(cyc + PL);
          wq_adr.push_back((m_zb + kk) % 128);
          if (m_issued == NISS - 1) m_done_cyc = cyc + PL + 1;
        end
        m_issued++;
      end
      if (e_wr) begin
        void'(wq_cyc.pop_front());
        void'(wq_adr.pop_front());
      end
      if (start && !m_job) begin
        m_job = 1; m_busy_from = cyc + 1; m_iss_from = cyc + 2;
        m_issued = 0; m_done_cyc = -1;
        m_xb = x_adr; m_yb = y_adr; m_zb = z_adr;
      end else if (e_done) begin
        m_job = 0;
      end
    end
  end

  // Record the stride-2 instance traffic
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en2) begin
        d2_x.push_back(x_rd_adr2);
        d2_y.push_back(y_rd_adr2);
      end
      if (z_wr_en2) d2_wr.push_back(z_wr_adr2);
      if (done2) d2_done++;
    end
  end

  task automatic pulse_start(input int x, input int y, input int z);
    @(posedge clk); #1;
    x_adr = 8'(x); y_adr = 8'(y); z_adr = 7'(z);
    start = 1'b1;
    t_start = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit toggle, input int restart_at);
    int i;
    i = 0;
    while (n_done == 0 && i < budget) begin
      @(posedge clk); #1;
      if (toggle) pe_ready = ~pe_ready;
      start = (i == restart_at);
      i++;
    end
    start = 1'b0;
    pe_ready = 1'b1;
    if (n_done == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout: got no done within %0d cycles expected one done", budget);
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_job(input string tag, input int first_z, input int last_z);
    chk({tag, "_rd_count"}, n_rd, NISS);
    chk({tag, "_wr_count"}, n_wr, NOUT);
    chk({tag, "_first_wr"}, first_wr_adr, first_z);
    chk({tag, "_last_wr"}, last_wr_adr, last_z);
    chk({tag, "_done_count"}, n_done, 1);
    $display("job %s: %0d reads, %0d writes, z %0d..%0d, %0d done", tag, n_rd, n_wr,
             first_wr_adr, last_wr_adr, n_done);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pe_ready = 1'b1;
    x_adr = '0; y_adr = '0; z_adr = '0;
    start2 = 1'b0; x2_adr = '0; y2_adr = '0; z2_adr = '0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Job 1: plain run, pe_ready held high
    clear_stats();
    pulse_start(16, 0, 17);
    wait_done(2000, 1'b0, -1);
    chk("t1_iss0_x", iss_x[0], 16);
    chk("t1_iss0_y", iss_y[0], 0);
    chk("t1_iss0_clr", iss_clr[0], 1);
    chk("t1_iss3_x", iss_x[3], 19);
    chk("t1_iss3_y", iss_y[3], 3);
    chk("t1_iss3_last", iss_last[3], 1);
    chk("t1_done_latency", done_cyc_seen - t_start, 296);
    check_job("t1", 17, 89);

    // Job 2: pe_ready toggling every cycle
    clear_stats();
    pulse_start(16, 0, 17);
    wait_done(4000, 1'b1, -1);
    check_job("t2", 17, 89);

    // Job 3: extra start mid-job must be ignored
    clear_stats();
    pulse_start(16, 0, 17);
    wait_done(2000, 1'b0, 50);
    check_job("t3", 17, 89);

    // Job 4: address wrap on both x and z
    clear_stats();
    pulse_start(250, 0, 120);
    wait_done(2000, 1'b0, -1);
    chk("t4_x_wraps", n_wrap_x, 4);
    check_job("t4", 120, 64);

    // Job 5: reset in the middle of RUN, then a fresh job
    clear_stats();
    pulse_start(16, 0, 17);
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_stats();
    repeat (30) @(posedge clk);
    #1;
    chk("t5_no_wr_after_rst", n_wr, 0);
    chk("t5_no_done_after_rst", n_done, 0);
    chk("t5_no_rd_after_rst", n_rd, 0);
    $display("job t5: aborted by reset, %0d writes and %0d done afterwards", n_wr, n_done);
    clear_stats();
    pulse_start(16, 0, 17);
    wait_done(2000, 1'b0, -1);
    check_job("t5b", 17, 89);

    // Job 6: stride 2, 12-word map -> 5 outputs of 4 taps
    @(posedge clk); #1;
    x2_adr = 8'd5; y2_adr = 8'd10; z2_adr = 7'd3; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int i = 0; i < 200 && d2_done == 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk("t6_rd_count", d2_x.size(), 20);
    chk("t6_wr_count", d2_wr.size(), 5);
    chk("t6_done_count", d2_done, 1);
    if (d2_x.size() == 20) begin
      chk("t6_iss4_x", d2_x[4], 7);
      chk("t6_iss19_x", d2_x[19], 16);
      for (int j = 0; j < 20; j++) begin
        chk("t6_x", d2_x[j], 5 + 2 * (j / 4) + (j % 4));
        chk("t6_y", d2_y[j], 10 + (j % 4));
      end
    end
    if (d2_wr.size() == 5) begin
      for (int j = 0; j < 5; j++) chk("t6_z", d2_wr[j], 3 + j);
    end
    $display("job t6: %0d reads, %0d writes, %0d done", d2_x.size(), d2_wr.size(), d2_done);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
